// File: rtl/spio_gen.sv
// -----------------------------------------------------------------------------
// spio_gen - special-purpose I/O peripheral on a Wishbone slave port.
//
// The peripheral drives the LEDs and the keypad columns through masked writes.
// It synchronises and debounces the keypad rows (active low) and the
// push-buttons (active high). A debounced button press or key press is latched
// into a write-one-to-clear pending bit. Enabled pending bits drive level
// interrupts.
//
// Register map (i_wb_addr):
//   0 IO  write: [7:0]   LED values,    [15:8]  LED write mask
//                [23:16] column values, [31:24] column write mask
//         read:  [7:0] LEDs, [15:8] debounced buttons,
//                [23:16] debounced rows, [31:24] columns
//   1 INT write: [7:0] btn_pend W1C, [15:8] row_pend W1C,
//                [23:16] btn_en load, [31:24] row_en load
//         read:  [7:0] btn_pend, [15:8] row_pend,
//                [23:16] btn_en, [31:24] row_en
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/addr/data Wishbone request; there is no stall
//   o_wb_ack, o_wb_data       single-cycle ack one cycle after the request,
//                             with registered read data
//   o_kp_col, i_kp_row        keypad column drive and row sense
//   i_btn                     push-buttons (asynchronous)
//   o_led                     LED drive
//   o_kp_int, o_btn_int       registered level interrupts
// -----------------------------------------------------------------------------
module spio_gen #(
    parameter int NLEDS = 4,
    parameter int NBTNS = 2,
    parameter int NCOLS = 4,
    parameter int NROWS = 4,
    parameter int DBNC  = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic             i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    output logic [NCOLS-1:0] o_kp_col,
    input  logic [NROWS-1:0] i_kp_row,
    input  logic [NBTNS-1:0] i_btn,
    output logic [NLEDS-1:0] o_led,
    output logic             o_kp_int,
    output logic             o_btn_int
);

    // Buttons and rows share one input path. Buttons occupy the low bits and
    // rows the high bits. Each line resets to its idle level.
    localparam int NIN = NBTNS + NROWS;
    localparam logic [NIN-1:0] IN_IDLE = {{NROWS{1'b1}}, {NBTNS{1'b0}}};
    localparam int CW = (DBNC > 1) ? $clog2(DBNC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC - 1);

    logic [NIN-1:0] raw;
    logic [NIN-1:0] meta_reg;
    logic [NIN-1:0] sync_reg;
    logic [NIN-1:0] deb_reg;
    logic [NIN-1:0] deb_next;

    assign raw = {i_kp_row, i_btn};

    // Per-line 2-flop synchroniser followed by a hold-time debouncer.
    for (genvar gi = 0; gi < NIN; gi++) begin : g_in
        logic [CW-1:0] cnt_reg;
        logic          take;

        // The debounced value accepts the new level after the mismatch has
        // been seen for DBNC consecutive cycles.
        assign take         = (sync_reg[gi] != deb_reg[gi]) && (cnt_reg == CNT_LAST);
        assign deb_next[gi] = take ? sync_reg[gi] : deb_reg[gi];

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                meta_reg[gi] <= IN_IDLE[gi];
                sync_reg[gi] <= IN_IDLE[gi];
                deb_reg[gi]  <= IN_IDLE[gi];
                cnt_reg      <= '0;
            end else begin
                meta_reg[gi] <= raw[gi];
                sync_reg[gi] <= meta_reg[gi];
                deb_reg[gi]  <= deb_next[gi];
                if ((sync_reg[gi] == deb_reg[gi]) || take) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    // The edges are taken from deb_next, so a pending bit is set on the same
    // clock edge on which the debounced value changes.
    logic [NBTNS-1:0] btn_rise;
    logic [NROWS-1:0] row_fall;
    assign btn_rise = deb_next[NBTNS-1:0] & ~deb_reg[NBTNS-1:0];
    assign row_fall = ~deb_next[NIN-1:NBTNS] & deb_reg[NIN-1:NBTNS];

    logic [NLEDS-1:0] led_reg;
    logic [NCOLS-1:0] col_reg;
    logic [NBTNS-1:0] btn_pend_reg;
    logic [NROWS-1:0] row_pend_reg;
    logic [NBTNS-1:0] btn_en_reg;
    logic [NROWS-1:0] row_en_reg;
    logic             ack_reg;
    logic [31:0]      rdata_reg;
    logic             kp_int_reg;
    logic             btn_int_reg;

    logic        req;
    logic        wr_io;
    logic        wr_int;
    logic [31:0] io_word;
    logic [31:0] int_word;

    assign req    = i_wb_cyc & i_wb_stb;
    assign wr_io  = req & i_wb_we & ~i_wb_addr;
    assign wr_int = req & i_wb_we &  i_wb_addr;

    assign io_word  = {8'(col_reg), 8'(deb_reg[NIN-1:NBTNS]),
                       8'(deb_reg[NBTNS-1:0]), 8'(led_reg)};
    assign int_word = {8'(row_en_reg), 8'(btn_en_reg),
                       8'(row_pend_reg), 8'(btn_pend_reg)};

    logic [NLEDS-1:0] led_mask;
    logic [NCOLS-1:0] col_mask;
    logic [NBTNS-1:0] btn_clr;
    logic [NROWS-1:0] row_clr;

    assign led_mask = i_wb_data[8 +: NLEDS];
    assign col_mask = i_wb_data[24 +: NCOLS];
    assign btn_clr  = wr_int ? i_wb_data[0 +: NBTNS] : '0;
    assign row_clr  = wr_int ? i_wb_data[8 +: NROWS] : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            led_reg      <= '0;
            col_reg      <= '0;
            btn_pend_reg <= '0;
            row_pend_reg <= '0;
            btn_en_reg   <= '0;
            row_en_reg   <= '0;
            ack_reg      <= 1'b0;
            rdata_reg    <= '0;
            kp_int_reg   <= 1'b0;
            btn_int_reg  <= 1'b0;
        end else begin
            ack_reg <= req;
            if (req && !i_wb_we) begin
                rdata_reg <= i_wb_addr ? int_word : io_word;
            end
            if (wr_io) begin
                led_reg <= (led_reg & ~led_mask) | (i_wb_data[0 +: NLEDS] & led_mask);
                col_reg <= (col_reg & ~col_mask) | (i_wb_data[16 +: NCOLS] & col_mask);
            end
            if (wr_int) begin
                btn_en_reg <= i_wb_data[16 +: NBTNS];
                row_en_reg <= i_wb_data[24 +: NROWS];
            end
            // The edge is OR-ed in after the clear, so a new event beats a
            // W1C in the same cycle.
            btn_pend_reg <= (btn_pend_reg & ~btn_clr) | btn_rise;
            row_pend_reg <= (row_pend_reg & ~row_clr) | row_fall;
            btn_int_reg  <= |(btn_pend_reg & btn_en_reg);
            kp_int_reg   <= |(row_pend_reg & row_en_reg);
        end
    end

    // Write-data bits beyond the configured widths are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, i_wb_data};

    assign o_wb_ack  = ack_reg;
    assign o_wb_data = rdata_reg;
    assign o_led     = led_reg;
    assign o_kp_col  = col_reg;
    assign o_btn_int = btn_int_reg;
    assign o_kp_int  = kp_int_reg;

endmodule

// File: tb/tb_spio_gen.sv
// -----------------------------------------------------------------------------
// tb_spio_gen - directed self-checking bench for spio_gen (DBNC=8, default
// widths). All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spio_gen;

    localparam int NLEDS = 4;
    localparam int NBTNS = 2;
    localparam int NCOLS = 4;
    localparam int NROWS = 4;
    localparam int DBNC  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cyc, stb, we, addr;
    logic [31:0]      wdata;
    logic             ack;
    logic [31:0]      rdata;
    logic [NCOLS-1:0] kp_col;
    logic [NROWS-1:0] kp_row;
    logic [NBTNS-1:0] btn;
    logic [NLEDS-1:0] led;
    logic             kp_int;
    logic             btn_int;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spio_gen #(
        .NLEDS(NLEDS), .NBTNS(NBTNS), .NCOLS(NCOLS), .NROWS(NROWS), .DBNC(DBNC)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_we  (we),
        .i_wb_addr(addr),
        .i_wb_data(wdata),
        .o_wb_ack (ack),
        .o_wb_data(rdata),
        .o_kp_col (kp_col),
        .i_kp_row (kp_row),
        .i_btn    (btn),
        .o_led    (led),
        .o_kp_int (kp_int),
        .o_btn_int(btn_int)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every step of the bench leaves time just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus request, sampled on the next edge; ack must be up right after it.
    task automatic wb_xfer(input logic w, input logic a, input logic [31:0] d,
                           output logic [31:0] r);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        check("ack", 32'(ack), 32'd1);
        r     = rdata;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        $display("xfer %s addr=%0d wdata=0x%08h rdata=0x%08h", w ? "WR" : "RD", a, d, r);
    endtask

    task automatic wb_write(input logic a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic wb_read(input string tag, input logic a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        addr   = 1'b0;
        wdata  = '0;
        kp_row = 4'hF;
        btn    = 2'b00;

        // Reset state
        #23;
        check("rst_led", 32'(led), 32'h0);
        check("rst_col", 32'(kp_col), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ints", {30'h0, kp_int, btn_int}, 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // Idle read: rows idle high, everything else zero
        wb_read("io_idle", 1'b0, 32'h000F_0000);
        tick();
        check("ack_single", 32'(ack), 32'h0);

        // Masked LED / column writes
        wb_write(1'b0, 32'h0F05_0305);
        check("led_w1", 32'(led), 32'h1);
        check("col_w1", 32'(kp_col), 32'h5);
        wb_write(1'b0, 32'h0008_0201);
        check("led_w2", 32'(led), 32'h1);
        check("col_w2", 32'(kp_col), 32'h5);
        wb_write(1'b0, 32'h0000_F0F0);   // mask bits above NLEDS only
        check("led_hi_mask", 32'(led), 32'h1);
        wb_read("io_after_wr", 1'b0, 32'h050F_0001);

        // Enable btn_en[0]
        wb_write(1'b1, 32'h0001_0000);

        // Glitch of DBNC-1 cycles must not pass
        btn = 2'b01;
        repeat (DBNC - 1) tick();
        btn = 2'b00;
        repeat (20) tick();
        check("glitch_int", 32'(btn_int), 32'h0);
        wb_read("glitch_int_reg", 1'b1, 32'h0001_0000);
        wb_read("glitch_io", 1'b0, 32'h050F_0001);

        // Clean step: debounced at edge DBNC+2, interrupt one edge later
        btn = 2'b01;
        for (int k = 1; k <= DBNC + 3; k++) begin
            tick();
            check($sformatf("btn_lat_%0d", k), 32'(btn_int), (k >= DBNC + 3) ? 32'd1 : 32'd0);
        end
        wb_read("btn_io", 1'b0, 32'h050F_0101);
        wb_read("btn_pend", 1'b1, 32'h0001_0001);

        // W1C clears pending; the interrupt drops one cycle later
        wb_write(1'b1, 32'h0001_0001);
        check("w1c_int_hold", 32'(btn_int), 32'h1);
        tick();
        check("w1c_int_drop", 32'(btn_int), 32'h0);
        wb_read("w1c_pend", 1'b1, 32'h0001_0000);

        // Release sets nothing
        btn = 2'b00;
        repeat (15) tick();
        wb_read("release_pend", 1'b1, 32'h0001_0000);
        wb_read("release_io", 1'b0, 32'h050F_0001);

        // W1C on the same edge as a new debounced rise: set wins
        btn = 2'b01;
        repeat (DBNC + 1) tick();
        wb_write(1'b1, 32'h0001_0001);
        wb_read("collide_pend", 1'b1, 32'h0001_0001);
        check("collide_int", 32'(btn_int), 32'h1);

        // Key press on row 2 with only row_en[2] enabled
        wb_write(1'b1, 32'h0400_0000);
        kp_row = 4'hB;
        for (int k = 1; k <= DBNC + 3; k++) begin
            tick();
            check($sformatf("kp_lat_%0d", k), 32'(kp_int), (k >= DBNC + 3) ? 32'd1 : 32'd0);
        end
        check("btn_int_disabled", 32'(btn_int), 32'h0);
        wb_read("kp_pend", 1'b1, 32'h0400_0401);
        wb_read("kp_io", 1'b0, 32'h050B_0101);
        wb_write(1'b1, 32'h0400_0400);
        check("kp_int_hold", 32'(kp_int), 32'h1);
        tick();
        check("kp_int_drop", 32'(kp_int), 32'h0);
        wb_read("kp_clr", 1'b1, 32'h0400_0001);

        // Enabling an already-pending bit raises the interrupt one cycle later
        wb_write(1'b0, 32'h0000_0F0F);
        check("led_all", 32'(led), 32'hF);
        wb_write(1'b1, 32'h0001_0000);
        check("late_en_wait", 32'(btn_int), 32'h0);
        tick();
        check("late_en_int", 32'(btn_int), 32'h1);
        kp_row = 4'hF;
        btn    = 2'b00;
        repeat (12) tick();
        check("pre_rst_int", 32'(btn_int), 32'h1);

        // Reset in the middle of a write
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        addr  = 1'b0;
        wdata = 32'h0F0F_0000;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_col", 32'(kp_col), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_ints", {30'h0, kp_int, btn_int}, 32'h0);
        tick();
        check("mid_rst_no_ack", 32'(ack), 32'h0);
        check("mid_rst_col_held", 32'(kp_col), 32'h0);
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_ack", 32'(ack), 32'h0);
        wb_read("post_rst_int", 1'b1, 32'h0000_0000);
        wb_read("post_rst_io", 1'b0, 32'h000F_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spio_gen.md
Name: spio_gen

Overview:
Parametrised special-purpose I/O peripheral on the Wishbone bus. It drives LEDs and keypad columns through masked writes, and it synchronises and debounces the keypad rows and push-buttons. Debounced edges are latched into write-one-to-clear pending bits, and enabled pending bits produce level interrupts for the interrupt controller. It replaces the fixed 4-LED/4x4/2-button SPIO in the SoC peripheral set.

Parameters:
NLEDS, 4, number of LED outputs (1..8)
NBTNS, 2, number of push-buttons (1..8), active high
NCOLS, 4, keypad column drive outputs (1..8)
NROWS, 4, keypad row sense inputs (1..8), active low (idle high)
DBNC, 1000, cycles a synchronised input must hold a new level before the debounced value takes it (>=1)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  1  register select: 0=IO, 1=INT
i_wb_data  in  32  write data
o_wb_ack  out  1  single-cycle acknowledge
o_wb_data  out  32  read data
o_kp_col  out  NCOLS  keypad column drive
i_kp_row  in  NROWS  keypad row sense (asynchronous)
i_btn  in  NBTNS  buttons (asynchronous)
o_led  out  NLEDS  LED drive
o_kp_int  out  1  keypad interrupt
o_btn_int  out  1  button interrupt

Behaviour:
- Reset (async, i_reset_n=0) sets:
  - o_led=0, o_kp_col=0, o_wb_ack=0, o_wb_data=0, o_kp_int=0, o_btn_int=0.
  - Synchronisers and debounced values: rows all-ones, buttons all-zero.
  - Debounce counters=0; pending=0; enable=0.
- Bus request is i_wb_cyc & i_wb_stb. There is no stall.
  - o_wb_ack rises exactly 1 cycle after each request and holds for 1 cycle.
  - o_wb_data is registered and valid with ack. It holds its last value otherwise.
- IO write (addr 0): for each bit i, the mask bit selects whether the value bit is copied or the output is held.
  - LEDs: led[i] <= data[8+i] ? data[i] : led[i].
  - Columns: col[i] <= data[24+i] ? data[16+i] : col[i].
  - Bits at or above NLEDS/NCOLS are ignored.
- IO read (addr 0): [7:0]=o_led, [15:8]=debounced buttons, [23:16]=debounced rows, [31:24]=o_kp_col. All fields are zero-extended.
- INT read (addr 1): [7:0]=btn_pend, [15:8]=row_pend, [23:16]=btn_en, [31:24]=row_en.
- INT write (addr 1):
  - Bits [15:0] are write-one-to-clear for the pending bits.
  - Bits [31:16] load the enable fields directly.
  - Both take effect on the cycle after the write.
- Input path per line: a 2-flop synchroniser, then a debouncer.
  - The debouncer's counter resets to 0 whenever sync == debounced.
  - Otherwise the counter increments. When it reaches DBNC-1 and sync still differs, the debounced value takes the sync value and the counter clears.
  - Total latency from a clean input step to the debounced change is DBNC+2 cycles.
  - A glitch shorter than DBNC cycles never changes the debounced value.
- Event capture:
  - A debounced button rising edge sets btn_pend[i].
  - A debounced row falling edge (key press) sets row_pend[i].
  - Release edges set nothing.
- Simultaneous edge and W1C on the same bit: set wins, and the bit stays 1.
- Interrupts are registered:
  - o_btn_int <= |(btn_pend & btn_en).
  - o_kp_int <= |(row_pend & row_en).
  - Each asserts 1 cycle after pending & enable is true and stays high until cleared or disabled.
- Pending bits latch regardless of enable. Enabling an already-pending bit raises the interrupt 1 cycle after the enable write completes.
- Reset asserted mid-transaction aborts it: no ack is produced for that request, and all state returns to reset values immediately.

Test Plan:
- Reset, then read addr 0 -> o_led=0, o_kp_col=0, read data 0x00_0F_00_00 (NROWS=4 idle rows), ack 1 cycle after stb.
- Write addr 0 data 0x0F05_0305, then write 0x0008_0201 -> after first o_led=0x1 (bits 0,1 masked; bit0=1,bit1=0), o_kp_col=0x5; after second o_led=0x1 (bit1 masked, value 0 held), o_kp_col=0x5 (col3 masked with 0, unchanged).
- DBNC=8: pulse i_btn[0] high for 6 cycles -> debounced and pending stay 0; hold high 20 cycles -> debounced btn[0]=1 at cycle 10 after step, btn_pend[0]=1.
- Enable row_en[2] (write addr 1 0x0400_0000), drive i_kp_row=0xB stable -> row_pend[2]=1 and o_kp_int=1 one cycle later; write addr 1 0x0400_0400 -> pending clears, o_kp_int drops next cycle.
- Issue W1C of btn_pend[0] on the exact cycle a new debounced rising edge on btn[0] occurs -> btn_pend[0] remains 1.
- Assert i_reset_n=0 mid-write with o_led=0xF and pending set -> all outputs 0 immediately, no ack, enables and pending cleared.
